hdlc_rx_frame_ctrl: RTL and testbench

Receive-side frame controller placed behind the HDLC receiver core. It gates the receiver's RxEnable and stores frame bytes in a circular byte buffer. A frame is committed only on a clean FrameEnd; aborted, CRC-bad and oversized frames are rolled back. Committed frames are replayed on a valid/ready byte stream with a last marker, and the block keeps per-outcome statistics.

---
 rtl/hdlc_rx_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_hdlc_rx_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller: buffers received bytes per frame, commits clean
// frames, rolls back bad or dropped ones and replays committed frames on a stream.
module hdlc_rx_frame_ctrl #(
    parameter int ADDR_W      = 11,
    parameter int LEN_FIFO_AW = 4,
    parameter int MAX_LEN     = 1024,
    parameter bit STRIP_CRC   = 1'b1
) (
    input  logic        Clk,
    input  logic        Rstn,
    input  logic        Enable,
    output logic        RxEnable,
    input  logic [8:0]  RxData,
    input  logic        RxDataValid,
    input  logic        RxFrameStart,
    input  logic        RxFrameEnd,
    input  logic        RxFrameError,
    input  logic        RxFrameAbort,
    output logic [7:0]  MData,
    output logic        MValid,
    output logic        MLast,
    input  logic        MReady,
    output logic [15:0] FramesOk,
    output logic [15:0] FramesBad,
    output logic [15:0] FramesDropped,
    output logic        Overflow
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int LFP_W = LEN_FIFO_AW + 1;
    localparam logic [PTR_W-1:0] DEPTH_C    = PTR_W'(1 << ADDR_W);
    localparam logic [LFP_W-1:0] LF_DEPTH_C = LFP_W'(1 << LEN_FIFO_AW);
    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_LEN_C  = STRIP_CRC ? LEN_W'(3) : LEN_W'(1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_FRAME = 2'd1, W_DROP = 2'd2} wstate_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        sat_inc = (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    wstate_e            wstate_q, wstate_d;
    rstate_e            rstate_q, rstate_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, base_ptr_q, base_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d, rem_q, rem_d, clen_s;
    logic [LFP_W-1:0]   lf_wr_q, lf_rd_q;
    logic [LEN_W-1:0]   lf_mem [1 << LEN_FIFO_AW];
    logic [7:0]         mem [1 << ADDR_W];
    logic               rx_en_q, ovf_q;
    logic [15:0]        ok_q, bad_q, drop_q;
    logic               we_s, start_s, inc_ok_s, inc_bad_s, inc_drop_s, ovf_s, lf_push_s, lf_pop_s;
    logic [ADDR_W-1:0]  waddr_s;
    logic               data_byte_s, full_s, base_full_s, lf_full_s, lf_empty_s, good_s;
    logic               issue_s, xfer_s, can_issue_s, pend_q, pend_last_q;
    logic [1:0]         occ_s;
    logic [7:0]         rdata_q, mdata_q, skid_data_q;
    logic               mvalid_q, mlast_q, skid_valid_q, skid_last_q;

    assign data_byte_s = RxDataValid && !RxData[8];
    assign full_s      = (wr_ptr_q - rd_ptr_q) == DEPTH_C;
    assign base_full_s = (base_ptr_q - rd_ptr_q) == DEPTH_C;
    assign lf_full_s   = (lf_wr_q - lf_rd_q) == LF_DEPTH_C;
    assign lf_empty_s  = lf_wr_q == lf_rd_q;
    assign good_s      = !RxFrameError && (len_q >= MIN_LEN_C);
    assign clen_s      = STRIP_CRC ? len_q - LEN_W'(2) : len_q;

    // Write FSM: frame acceptance, commit and rollback decisions
    always_comb begin
        wstate_d   = wstate_q;
        wr_ptr_d   = wr_ptr_q;
        base_ptr_d = base_ptr_q;
        len_d      = len_q;
        we_s       = 1'b0;
        waddr_s    = wr_ptr_q[ADDR_W-1:0];
        start_s    = 1'b0;
        inc_ok_s   = 1'b0;
        inc_bad_s  = 1'b0;
        inc_drop_s = 1'b0;
        ovf_s      = 1'b0;
        lf_push_s  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (RxFrameStart && rx_en_q) start_s = 1'b1;
                else                         wstate_d = W_IDLE;
            end
            W_FRAME: begin
                if (!rx_en_q || RxFrameAbort) begin
                    wr_ptr_d   = base_ptr_q;
                    inc_drop_s = 1'b1;
                    wstate_d   = W_IDLE;
                end else if (RxFrameEnd) begin
                    wr_ptr_d = base_ptr_q;
                    wstate_d = W_IDLE;
                    if (lf_full_s) begin
                        inc_drop_s = 1'b1;
                        ovf_s      = 1'b1;
                    end else if (good_s) begin
                        lf_push_s  = 1'b1;
                        base_ptr_d = base_ptr_q + PTR_W'(clen_s);
                        wr_ptr_d   = base_ptr_q + PTR_W'(clen_s);
                        inc_ok_s   = 1'b1;
                    end else begin
                        inc_bad_s  = 1'b1;
                    end
                end else if (RxFrameStart) begin
                    inc_bad_s = 1'b1;
                    start_s   = 1'b1;
                end else if (data_byte_s) begin
                    if (full_s || (len_q == MAX_LEN_C)) begin
                        wr_ptr_d   = base_ptr_q;
                        inc_drop_s = 1'b1;
                        ovf_s      = 1'b1;
                        wstate_d   = W_DROP;
                    end else begin
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        len_d    = len_q + LEN_W'(1);
                    end
                end else begin
                    wstate_d = W_FRAME;
                end
            end
            W_DROP: begin
                if (!rx_en_q || RxFrameAbort || RxFrameEnd) wstate_d = W_IDLE;
                else if (RxFrameStart)                      start_s  = 1'b1;
                else                                        wstate_d = W_DROP;
            end
            default: begin
                wstate_d = W_IDLE;
                wr_ptr_d = base_ptr_q;
            end
        endcase
        // A (re)started frame always begins at base_ptr with the coincident byte
        if (start_s) begin
            wstate_d = W_FRAME;
            wr_ptr_d = base_ptr_q;
            len_d    = '0;
            if (data_byte_s && base_full_s) begin
                inc_drop_s = 1'b1;
                ovf_s      = 1'b1;
                wstate_d   = W_DROP;
            end else if (data_byte_s) begin
                we_s     = 1'b1;
                waddr_s  = base_ptr_q[ADDR_W-1:0];
                wr_ptr_d = base_ptr_q + PTR_W'(1);
                len_d    = LEN_W'(1);
            end else begin
                len_d    = '0;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    assign xfer_s      = mvalid_q && MReady;
    assign occ_s       = {1'b0, mvalid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
    assign can_issue_s = (occ_s < 2'd2) || ((occ_s == 2'd2) && xfer_s);

    // Read FSM: pop a length, issue RAM reads while the skid stage has room
    always_comb begin
        rstate_d = rstate_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        lf_pop_s = 1'b0;
        issue_s  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (!lf_empty_s) begin
                    lf_pop_s = 1'b1;
                    rem_d    = lf_mem[lf_rd_q[LEN_FIFO_AW-1:0]];
                    rstate_d = R_DATA;
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_DATA: begin
                if ((rem_q != '0) && can_issue_s) begin
                    issue_s  = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    rem_d    = rem_q - LEN_W'(1);
                end else if ((rem_q == '0) && xfer_s && mlast_q) begin
                    rstate_d = R_IDLE;
                end else begin
                    rstate_d = R_DATA;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Byte buffer and length FIFO storage
    always_ff @(posedge Clk) begin
        if (we_s) mem[waddr_s] <= RxData[7:0];
        if (issue_s) rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        if (lf_push_s) lf_mem[lf_wr_q[LEN_FIFO_AW-1:0]] <= clen_s;
    end

    // Control state, pointers, counters and the two-entry output skid
    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            wstate_q <= W_IDLE;      rstate_q <= R_IDLE;
            wr_ptr_q <= '0;          base_ptr_q <= '0;      rd_ptr_q <= '0;
            len_q <= '0;             rem_q <= '0;
            lf_wr_q <= '0;           lf_rd_q <= '0;
            rx_en_q <= 1'b0;         ovf_q <= 1'b0;
            ok_q <= 16'd0;           bad_q <= 16'd0;        drop_q <= 16'd0;
            pend_q <= 1'b0;          pend_last_q <= 1'b0;
            mvalid_q <= 1'b0;        mlast_q <= 1'b0;       mdata_q <= 8'd0;
            skid_valid_q <= 1'b0;    skid_last_q <= 1'b0;   skid_data_q <= 8'd0;
        end else begin
            wstate_q <= wstate_d;    rstate_q <= rstate_d;
            wr_ptr_q <= wr_ptr_d;    base_ptr_q <= base_ptr_d; rd_ptr_q <= rd_ptr_d;
            len_q <= len_d;          rem_q <= rem_d;
            lf_wr_q <= lf_wr_q + LFP_W'(lf_push_s);
            lf_rd_q <= lf_rd_q + LFP_W'(lf_pop_s);
            rx_en_q <= Enable;       ovf_q <= ovf_s;
            ok_q <= sat_inc(ok_q, inc_ok_s);
            bad_q <= sat_inc(bad_q, inc_bad_s);
            drop_q <= sat_inc(drop_q, inc_drop_s);
            pend_q <= issue_s;
            pend_last_q <= issue_s && (rem_q == LEN_W'(1));
            if (xfer_s) begin
                if (skid_valid_q) begin
                    mdata_q <= skid_data_q;
                    mlast_q <= skid_last_q;
                    skid_valid_q <= pend_q;
                    skid_data_q <= rdata_q;
                    skid_last_q <= pend_last_q;
                end else if (pend_q) begin
                    mdata_q <= rdata_q;
                    mlast_q <= pend_last_q;
                end else begin
                    mvalid_q <= 1'b0;
                    mlast_q <= 1'b0;
                end
            end else if (pend_q && !mvalid_q) begin
                mvalid_q <= 1'b1;
                mdata_q <= rdata_q;
                mlast_q <= pend_last_q;
            end else if (pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q <= rdata_q;
                skid_last_q <= pend_last_q;
            end else begin
                mvalid_q <= mvalid_q;
            end
        end
    end

    assign RxEnable      = rx_en_q;
    assign MData         = mdata_q;
    assign MValid        = mvalid_q;
    assign MLast         = mlast_q;
    assign FramesOk      = ok_q;
    assign FramesBad     = bad_q;
    assign FramesDropped = drop_q;
    assign Overflow      = ovf_q;
endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Directed bench for hdlc_rx_frame_ctrl: a table of single-frame outcomes plus
// hand-written sequences for overflow, oversize, enable drop, restart and back-pressure.
module tb_hdlc_rx_frame_ctrl;
    logic        Clk = 1'b0, Rstn = 1'b0, Enable = 1'b0, RxEnable;
    logic [8:0]  RxData = 9'd0;
    logic        RxDataValid = 1'b0, RxFrameStart = 1'b0, RxFrameEnd = 1'b0;
    logic        RxFrameError = 1'b0, RxFrameAbort = 1'b0;
    logic [7:0]  MData;
    logic        MValid, MLast, MReady = 1'b0, Overflow;
    logic [15:0] FramesOk, FramesBad, FramesDropped;

    hdlc_rx_frame_ctrl dut (
        .Clk(Clk), .Rstn(Rstn), .Enable(Enable), .RxEnable(RxEnable),
        .RxData(RxData), .RxDataValid(RxDataValid), .RxFrameStart(RxFrameStart),
        .RxFrameEnd(RxFrameEnd), .RxFrameError(RxFrameError), .RxFrameAbort(RxFrameAbort),
        .MData(MData), .MValid(MValid), .MLast(MLast), .MReady(MReady),
        .FramesOk(FramesOk), .FramesBad(FramesBad), .FramesDropped(FramesDropped),
        .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int nbytes;
        int kind;   // 0 clean end, 1 CRC error, 2 abort, 3 abort+end together
        int d_ok;
        int d_bad;
        int d_drop;
        int n_out;
    } vec_t;

    int         checks = 0, failures = 0;
    int         exp_ok = 0, exp_bad = 0, exp_drop = 0, exp_base = 0;
    int         ovf_seen = 0;
    logic [8:0] got_q[$], exp_q[$];
    logic       prev_stall = 1'b0, prev_last = 1'b0, rand_rdy = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Output monitor: collects transfers, counts Overflow pulses, checks stall stability
    always @(negedge Clk) begin
        if (Rstn) begin
            if (prev_stall) begin
                checks++;
                if (!MValid || MData != prev_data || MLast != prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b d=%0h l=%0b, want v=1 d=%0h l=%0b",
                             MValid, MData, MLast, prev_data, prev_last);
                end
            end
            if (MValid && MReady) got_q.push_back({MLast, MData});
            if (Overflow) ovf_seen++;
            prev_stall = MValid && !MReady;
            prev_data  = MData;
            prev_last  = MLast;
        end
    end

    task automatic cyc(input logic st, input logic en, input logic er, input logic ab,
                       input logic v, input logic [8:0] d);
        RxFrameStart = st; RxFrameEnd = en; RxFrameError = er; RxFrameAbort = ab;
        RxDataValid = v; RxData = d;
        if (rand_rdy) MReady = 1'($urandom_range(0, 1));
        @(posedge Clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    // kind: 0 clean, 1 CRC error, 2 abort, 3 abort+end, 4 no closing event
    task automatic send_frame(input int n, input int seed, input int kind);
        for (int i = 0; i < n; i++)
            cyc(i == 0, 1'b0, 1'b0, 1'b0, 1'b1, {1'b0, 8'(seed + i)});
        case (kind)
            0: cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h17E);
            1: cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h17E);
            2: cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
            3: cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h17E);
            default: ;
        endcase
    endtask

    task automatic expect_out(input int nout, input int seed);
        for (int i = 0; i < nout; i++)
            exp_q.push_back({(i == nout - 1), 8'(seed + i)});
        exp_base = (exp_base + nout) % 4096;
    endtask

    task automatic drain(input string tag, output int lasts);
        int budget, w, mis;
        budget = exp_q.size() * 6 + 200;
        w = 0;
        while (got_q.size() < exp_q.size() && w < budget) begin
            idle(1);
            w++;
        end
        idle(10);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        mis = 0;
        lasts = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) mis++;
            if (got_q[i][8]) lasts++;
        end
        chk({tag, "_byte_mismatches"}, mis, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_FramesOk"}, FramesOk, exp_ok);
        chk({tag, "_FramesBad"}, FramesBad, exp_bad);
        chk({tag, "_FramesDropped"}, FramesDropped, exp_drop);
        chk({tag, "_base_ptr"}, int'(dut.base_ptr_q), exp_base);
    endtask

    initial begin
        vec_t vt[8];
        int   lasts, ovf0, n;
        vt[0] = '{7, 0, 1, 0, 0, 5};
        vt[1] = '{7, 1, 0, 1, 0, 0};
        vt[2] = '{3, 2, 0, 0, 1, 0};
        vt[3] = '{4, 0, 1, 0, 0, 2};
        vt[4] = '{2, 0, 0, 1, 0, 0};
        vt[5] = '{3, 0, 1, 0, 0, 1};
        vt[6] = '{6, 3, 0, 0, 1, 0};
        vt[7] = '{1, 0, 0, 1, 0, 0};

        Enable = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        chk("rst_RxEnable", RxEnable, 0);
        chk("rst_MValid", MValid, 0);
        chk("rst_MLast", MLast, 0);
        chk("rst_MData", MData, 0);
        chk("rst_FramesOk", FramesOk, 0);
        chk("rst_FramesBad", FramesBad, 0);
        chk("rst_FramesDropped", FramesDropped, 0);
        chk("rst_Overflow", Overflow, 0);
        Rstn = 1'b1;
        MReady = 1'b1;
        @(posedge Clk); #1;
        chk("RxEnable_follows", RxEnable, 1);

        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].nbytes, 16 * i + 1, vt[i].kind);
            idle(3);
            expect_out(vt[i].n_out, 16 * i + 1);
            exp_ok += vt[i].d_ok;
            exp_bad += vt[i].d_bad;
            exp_drop += vt[i].d_drop;
            drain($sformatf("vec%0d", i), lasts);
            chk_state($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_wr_ptr", i), int'(dut.wr_ptr_q), exp_base);
            chk($sformatf("vec%0d_rd_ptr", i), int'(dut.rd_ptr_q), exp_base);
        end

        // Restart without a closing flag: first frame counts as bad
        send_frame(4, 200, 4);
        send_frame(6, 210, 0);
        idle(3);
        exp_bad++; exp_ok++;
        expect_out(4, 210);
        drain("restart", lasts);
        chk_state("restart");

        // Enable dropped mid-frame
        send_frame(3, 60, 4);
        Enable = 1'b0;
        idle(3);
        Enable = 1'b1;
        idle(2);
        exp_drop++;
        send_frame(8, 70, 0);
        idle(3);
        exp_ok++;
        expect_out(6, 70);
        drain("enable_drop", lasts);
        chk_state("enable_drop");

        // Buffer overflow with output stalled: third 700-byte frame is dropped
        MReady = 1'b0;
        ovf0 = ovf_seen;
        for (int f = 0; f < 3; f++) begin
            send_frame(700, 7 * f, 0);
            idle(2);
        end
        exp_ok += 2; exp_drop++;
        expect_out(698, 0);
        expect_out(698, 7);
        chk_state("overflow");
        chk("overflow_pulses", ovf_seen - ovf0, 1);
        MReady = 1'b1;
        drain("overflow", lasts);
        chk("overflow_lasts", lasts, 2);
        chk("overflow_rd_ptr", int'(dut.rd_ptr_q), exp_base);

        // Oversize frame, then a maximal 1024-byte frame, then a small one
        ovf0 = ovf_seen;
        send_frame(1100, 90, 0);
        idle(3);
        exp_drop++;
        chk("oversize_pulses", ovf_seen - ovf0, 1);
        send_frame(1024, 33, 0);
        idle(3);
        send_frame(10, 120, 0);
        idle(3);
        exp_ok += 2;
        expect_out(1022, 33);
        expect_out(8, 120);
        drain("oversize", lasts);
        chk_state("oversize");

        // Random back-pressure over 50 frames
        rand_rdy = 1'b1;
        for (int f = 0; f < 50; f++) begin
            n = $urandom_range(3, 40);
            send_frame(n, 3 * f, 0);
            expect_out(n - 2, 3 * f);
            exp_ok++;
            idle(2 * n);
        end
        drain("random", lasts);
        rand_rdy = 1'b0;
        MReady = 1'b1;
        chk("random_mlast_count", lasts, 50);
        chk_state("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
